// File: rtl/imem_port_arbiter.sv
`default_nettype none
//============================================================================
// Module      : imem_port_arbiter
// Description : Round-robin arbiter that shares one read port of the
//               byte-addressed memory model between the IF (fetch) and MEM
//               (load / loader) requesters, with a watchdog that aborts an
//               access whose DATA_READY never arrives.
// Revision    : 1.0 - initial release
//============================================================================
module imem_port_arbiter #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IF_REQ,
    input  logic [ADDRESS_SIZE-1:0] IF_ADDR,
    output logic [WORD_SIZE-1:0]    IF_DATA,
    output logic                    IF_READY,
    input  logic                    MEM_REQ,
    input  logic [ADDRESS_SIZE-1:0] MEM_ADDR,
    output logic [WORD_SIZE-1:0]    MEM_DATA,
    output logic                    MEM_READY,
    output logic                    ERR,
    output logic                    ENABLE,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    input  logic [WORD_SIZE-1:0]    DATA,
    input  logic                    DATA_READY,
    output logic                    BUSY
);

    // Counter only has to reach TIMEOUT_CYCLES-1; one spare value keeps it
    // from ever wrapping.
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic c_OWNER_IF  = 1'b0;
    localparam logic c_OWNER_MEM = 1'b1;

    logic [1:0]              r_state;
    logic                    r_owner;
    logic                    r_last;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_enable;
    logic [ADDRESS_SIZE-1:0] r_address;
    logic [WORD_SIZE-1:0]    r_if_data;
    logic                    r_if_ready;
    logic [WORD_SIZE-1:0]    r_mem_data;
    logic                    r_mem_ready;
    logic                    r_err;
    logic                    r_busy;

    logic                    w_pick_mem;
    logic                    w_any_req;
    logic                    w_timeout;

    // MEM wins when it is the only requester, or on a tie when IF went last.
    assign w_pick_mem = MEM_REQ && (!IF_REQ || (r_last == c_OWNER_IF));
    assign w_any_req  = IF_REQ || MEM_REQ;
    assign w_timeout  = (r_cnt == c_CNT_LAST);

    // Arbitration FSM with every output register updated in one place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_owner     <= c_OWNER_IF;
            r_last      <= c_OWNER_MEM;
            r_cnt       <= '0;
            r_enable    <= 1'b0;
            r_address   <= '0;
            r_if_data   <= '0;
            r_if_ready  <= 1'b0;
            r_mem_data  <= '0;
            r_mem_ready <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_pick_mem ? c_OWNER_MEM : c_OWNER_IF;
                        r_address <= w_pick_mem ? MEM_ADDR : IF_ADDR;
                        r_enable  <= 1'b1;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_BUSY;
                    end
                end

                c_BUSY: begin
                    if (DATA_READY || w_timeout) begin
                        // DATA is only looked at when DATA_READY is high, so an
                        // undriven bus never reaches the requester.
                        if (r_owner == c_OWNER_MEM) begin
                            r_mem_data  <= DATA_READY ? DATA : '0;
                            r_mem_ready <= 1'b1;
                        end else begin
                            r_if_data   <= DATA_READY ? DATA : '0;
                            r_if_ready  <= 1'b1;
                        end
                        r_err    <= !DATA_READY;
                        r_enable <= 1'b0;
                        r_last   <= r_owner;
                        r_state  <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_RESP: begin
                    r_if_ready  <= 1'b0;
                    r_mem_ready <= 1'b0;
                    r_err       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_IDLE;
                end

                default: begin
                    r_enable    <= 1'b0;
                    r_if_ready  <= 1'b0;
                    r_mem_ready <= 1'b0;
                    r_err       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign ENABLE    = r_enable;
    assign ADDRESS   = r_address;
    assign IF_DATA   = r_if_data;
    assign IF_READY  = r_if_ready;
    assign MEM_DATA  = r_mem_data;
    assign MEM_READY = r_mem_ready;
    assign ERR       = r_err;
    assign BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_imem_port_arbiter
// Description : Directed scoreboard bench for imem_port_arbiter with a
//               one-cycle memory stub that can be stalled.
// Revision    : 1.0 - initial release
//============================================================================
module tb_imem_port_arbiter;

    localparam int c_WS = 32;
    localparam int c_AS = 16;
    localparam int c_TO = 8;

    logic            clk;
    logic            rst;
    logic            IF_REQ;
    logic [c_AS-1:0] IF_ADDR;
    logic [c_WS-1:0] IF_DATA;
    logic            IF_READY;
    logic            MEM_REQ;
    logic [c_AS-1:0] MEM_ADDR;
    logic [c_WS-1:0] MEM_DATA;
    logic            MEM_READY;
    logic            ERR;
    logic            ENABLE;
    logic [c_AS-1:0] ADDRESS;
    logic [c_WS-1:0] DATA       = 32'hBAD0_BAD0;
    logic            DATA_READY = 1'b0;
    logic            BUSY;

    imem_port_arbiter #(
        .WORD_SIZE      (c_WS),
        .ADDRESS_SIZE   (c_AS),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .IF_REQ     (IF_REQ),
        .IF_ADDR    (IF_ADDR),
        .IF_DATA    (IF_DATA),
        .IF_READY   (IF_READY),
        .MEM_REQ    (MEM_REQ),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .MEM_READY  (MEM_READY),
        .ERR        (ERR),
        .ENABLE     (ENABLE),
        .ADDRESS    (ADDRESS),
        .DATA       (DATA),
        .DATA_READY (DATA_READY),
        .BUSY       (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stub: word at byte address a holds {16'hC0DE, a}, except 0x0004.
    logic [c_WS-1:0] mem [0:63];
    logic            stall = 1'b0;

    // One-cycle memory; BAD0BAD0 stands in for the undriven bus when not ready.
    always @(posedge clk) begin
        DATA_READY <= ENABLE && !DATA_READY && !stall;
        DATA       <= (ENABLE && !DATA_READY && !stall) ? mem[ADDRESS[7:2]] : 32'hBAD0_BAD0;
    end

    typedef struct packed {
        logic            port;   // 0 = IF, 1 = MEM
        logic [c_WS-1:0] data;
        logic            err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_exp(input logic port, input logic [c_WS-1:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    // Monitor: every READY pulse consumes one expected response.
    always @(negedge clk) begin
        check("ready_exclusive", {63'd0, IF_READY & MEM_READY}, 64'd0);
        if (IF_READY || MEM_READY) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", {62'd0, IF_READY, MEM_READY}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ready_port", {63'd0, MEM_READY}, {63'd0, mon_e.port});
                check("ready_data", {32'd0, (mon_e.port ? MEM_DATA : IF_DATA)}, {32'd0, mon_e.data});
                check("ready_err", {63'd0, ERR}, {63'd0, mon_e.err});
            end
        end else begin
            check("err_without_ready", {63'd0, ERR}, 64'd0);
        end
    end

    task automatic if_access(input logic [c_AS-1:0] addr, output int waited);
        IF_REQ  = 1'b1;
        IF_ADDR = addr;
        waited  = 0;
        while (1) begin
            @(posedge clk); #1;
            waited++;
            if (IF_READY || waited >= 40) break;
        end
        if (!IF_READY) begin
            n_checks++;
            n_fail++;
            $display("FAIL if_ready_timeout: got no IF_READY after %0d cycles, addr %0h", waited, addr);
        end
        IF_REQ = 1'b0;
    endtask

    task automatic mem_access(input logic [c_AS-1:0] addr, output int waited);
        MEM_REQ  = 1'b1;
        MEM_ADDR = addr;
        waited   = 0;
        while (1) begin
            @(posedge clk); #1;
            waited++;
            if (MEM_READY || waited >= 40) break;
        end
        if (!MEM_READY) begin
            n_checks++;
            n_fail++;
            $display("FAIL mem_ready_timeout: got no MEM_READY after %0d cycles, addr %0h", waited, addr);
        end
        MEM_REQ = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int w1;
        int w2;
        int waited;

        for (int i = 0; i < 64; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
        mem[1] = 32'hDEAD_BEEF;

        rst      = 1'b0;
        IF_REQ   = 1'b0;
        IF_ADDR  = '0;
        MEM_REQ  = 1'b0;
        MEM_ADDR = '0;

        // Reset state
        do_reset();
        check("rst_enable",    {63'd0, ENABLE},    64'd0);
        check("rst_address",   {48'd0, ADDRESS},   64'd0);
        check("rst_if_data",   {32'd0, IF_DATA},   64'd0);
        check("rst_if_ready",  {63'd0, IF_READY},  64'd0);
        check("rst_mem_data",  {32'd0, MEM_DATA},  64'd0);
        check("rst_mem_ready", {63'd0, MEM_READY}, 64'd0);
        check("rst_err",       {63'd0, ERR},       64'd0);
        check("rst_busy",      {63'd0, BUSY},      64'd0);

        // 1: single IF read with exact latency
        push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
        IF_REQ  = 1'b1;
        IF_ADDR = 16'h0004;
        @(posedge clk); #1;
        check("t1_enable",  {63'd0, ENABLE},  64'd1);
        check("t1_address", {48'd0, ADDRESS}, 64'h0004);
        check("t1_busy",    {63'd0, BUSY},    64'd1);
        @(posedge clk); #1;
        check("t1_ready_early", {63'd0, IF_READY}, 64'd0);
        @(posedge clk); #1;
        check("t1_ready", {63'd0, IF_READY}, 64'd1);
        check("t1_mem_ready", {63'd0, MEM_READY}, 64'd0);
        check("t1_enable_off", {63'd0, ENABLE}, 64'd0);
        IF_REQ = 1'b0;
        @(posedge clk); #1;
        check("t1_ready_pulse", {63'd0, IF_READY}, 64'd0);
        check("t1_idle", {63'd0, BUSY}, 64'd0);
        check("t1_mem_data_untouched", {32'd0, MEM_DATA}, 64'd0);

        // 2: simultaneous requests after reset -> IF, MEM, IF
        do_reset();
        push_exp(1'b0, 32'hC0DE_0010, 1'b0);
        push_exp(1'b1, 32'hC0DE_0020, 1'b0);
        push_exp(1'b0, 32'hC0DE_0014, 1'b0);
        fork
            begin
                if_access(16'h0010, w1);
                check("t2_if_first_latency", 64'(w1), 64'd3);
                if_access(16'h0014, w1);
                check("t2_if_second_wait", 64'(w1), 64'd8);
            end
            begin
                mem_access(16'h0020, w2);
                check("t2_mem_wait", 64'(w2), 64'd7);
            end
        join
        idle(2);

        // 3: back-to-back IF stream, one access per 4 cycles
        push_exp(1'b0, 32'hC0DE_0000, 1'b0);
        push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
        push_exp(1'b0, 32'hC0DE_0008, 1'b0);
        if_access(16'h0000, waited);
        check("t3_lat0", 64'(waited), 64'd3);
        if_access(16'h0004, waited);
        check("t3_period1", 64'(waited), 64'd4);
        if_access(16'h0008, waited);
        check("t3_period2", 64'(waited), 64'd4);
        idle(2);

        // 4: watchdog abort, then a normal access
        stall = 1'b1;
        push_exp(1'b0, 32'h0000_0000, 1'b1);
        if_access(16'h0030, waited);
        check("t4_timeout_cycles", 64'(waited), 64'(c_TO + 1));
        check("t4_busy_in_resp", {63'd0, BUSY}, 64'd1);
        stall = 1'b0;
        push_exp(1'b0, 32'hC0DE_0034, 1'b0);
        if_access(16'h0034, waited);
        check("t4_recover_wait", 64'(waited), 64'd4);
        idle(2);

        // 5: reset while BUSY, then IF priority from IDLE
        IF_REQ  = 1'b1;
        IF_ADDR = 16'h0040;
        @(posedge clk); #1;
        check("t5_granted", {63'd0, BUSY}, 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5_rst_enable", {63'd0, ENABLE},   64'd0);
        check("t5_rst_busy",   {63'd0, BUSY},     64'd0);
        check("t5_rst_ready",  {63'd0, IF_READY}, 64'd0);
        rst = 1'b1;
        push_exp(1'b0, 32'hC0DE_0040, 1'b0);
        push_exp(1'b1, 32'hC0DE_0050, 1'b0);
        fork
            if_access(16'h0040, w1);
            mem_access(16'h0050, w2);
        join
        check("t5_if_wait",  64'(w1), 64'd3);
        check("t5_mem_wait", 64'(w2), 64'd7);
        idle(2);

        // 6: MEM drops REQ mid-BUSY; access still completes, IF goes next
        push_exp(1'b1, 32'hC0DE_0060, 1'b0);
        MEM_REQ  = 1'b1;
        MEM_ADDR = 16'h0060;
        @(posedge clk); #1;
        check("t6_enable", {63'd0, ENABLE}, 64'd1);
        MEM_REQ = 1'b0;
        waited  = 0;
        while (!MEM_READY && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("t6_mem_ready_wait", 64'(waited), 64'd2);
        push_exp(1'b0, 32'hC0DE_0070, 1'b0);
        push_exp(1'b1, 32'hC0DE_0064, 1'b0);
        fork
            if_access(16'h0070, w1);
            mem_access(16'h0064, w2);
        join
        check("t6_if_next", 64'(w1), 64'd4);
        check("t6_mem_after", 64'(w2), 64'd8);
        idle(4);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
